// File: rtl/systolic_feed_scheduler_pkg.sv
// ============================================================================
//  systolic_feed_scheduler_pkg
//  Shared sizing defaults, FSM state encoding and stream-length helper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package systolic_feed_scheduler_pkg;

    localparam int ARRAYWIDTH_DEF   = 4;
    localparam int DATASIZE_DEF     = 8;
    localparam int DSP_DELAY_DEF    = 3;
    localparam int DRAIN_CYCLES_DEF = 8;
    localparam int CNT_W_DEF        = 16;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_CLEAR  = 3'd1;
    localparam logic [STATE_W-1:0] S_LOAD   = 3'd2;
    localparam logic [STATE_W-1:0] S_STREAM = 3'd3;
    localparam logic [STATE_W-1:0] S_DRAIN  = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd5;
    localparam logic [STATE_W-1:0] S_ABORT  = 3'd6;

    // Skewed shift-out of a W-lane bank spans 2W-1 steps of DSP_DELAY cycles.
    function automatic int stream_len(input int array_width, input int dsp_delay);
        return (2 * array_width - 1) * dsp_delay;
    endfunction

    localparam int STREAM_LEN_DEF = stream_len(ARRAYWIDTH_DEF, DSP_DELAY_DEF);

endpackage

`default_nettype wire

// File: rtl/systolic_feed_scheduler.sv
// ============================================================================
//  systolic_feed_scheduler
//  Clears, loads and streams one operand tile into an input shifter bank.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_feed_scheduler
    import systolic_feed_scheduler_pkg::*;
#(
    parameter int ARRAYWIDTH   = ARRAYWIDTH_DEF,
    parameter int DATASIZE     = DATASIZE_DEF,
    parameter int DSP_DELAY    = DSP_DELAY_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ARRAYWIDTH*DATASIZE-1:0] in_data,
    output logic                           sh_clr,
    output logic                           sh_load_en,
    output logic                           sh_out_en,
    output logic [ARRAYWIDTH*DATASIZE-1:0] sh_data,
    output logic [CNT_W-1:0]               load_beat
);

    localparam int              STREAM_LEN  = stream_len(ARRAYWIDTH, DSP_DELAY);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] BEAT_LAST   = CNT_W'(ARRAYWIDTH - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   beat_q,  beat_d;
    logic               accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

    // One down-counter paces both STREAM and DRAIN; it is reloaded on entry to each.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        if (abort && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLEAR;
                        beat_d  = '0;
                    end
                end
                S_CLEAR: state_d = S_LOAD;
                S_LOAD: begin
                    if (accept) begin
                        beat_d = beat_q + CNT_W'(1);
                        if (beat_q == BEAT_LAST) begin
                            state_d = S_STREAM;
                            cnt_d   = STREAM_LAST;
                        end
                    end
                end
                S_STREAM: begin
                    if (cnt_q == '0) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DRAIN;
                            cnt_d   = DRAIN_LAST;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ABORT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Enable is combinational so the beat and its load strobe reach the shifters together.
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        sh_clr     = (state_q == S_CLEAR) || (state_q == S_ABORT);
        sh_out_en  = (state_q == S_STREAM);
        in_ready   = (state_q == S_LOAD) && !abort;
        accept     = in_ready && in_valid;
        sh_load_en = accept;
        sh_data    = in_data;
        load_beat  = beat_q;
    end

endmodule

`default_nettype wire
